// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the scanned 7-segment counter.
//   - active-high segment glyphs for 0-F plus BLANK ([0]=a .. [6]=g)
//   - segment bit indices A..G
//   - per-digit maximum for decimal and hex counting
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] GLYPH_0   = 7'h3F;
  localparam logic [6:0] GLYPH_1   = 7'h06;
  localparam logic [6:0] GLYPH_2   = 7'h5B;
  localparam logic [6:0] GLYPH_3   = 7'h4F;
  localparam logic [6:0] GLYPH_4   = 7'h66;
  localparam logic [6:0] GLYPH_5   = 7'h6D;
  localparam logic [6:0] GLYPH_6   = 7'h7D;
  localparam logic [6:0] GLYPH_7   = 7'h07;
  localparam logic [6:0] GLYPH_8   = 7'h7F;
  localparam logic [6:0] GLYPH_9   = 7'h6F;
  localparam logic [6:0] GLYPH_A   = 7'h77;
  localparam logic [6:0] GLYPH_B   = 7'h7C;
  localparam logic [6:0] GLYPH_C   = 7'h39;
  localparam logic [6:0] GLYPH_D   = 7'h5E;
  localparam logic [6:0] GLYPH_E   = 7'h79;
  localparam logic [6:0] GLYPH_F   = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIG_MAX_DEC = 4'd9;
  localparam logic [3:0] DIG_MAX_HEX = 4'd15;

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble-to-glyph decoder, active-high segments.
//   nib  in  4  digit value 0-F
//   seg  out 7  [0]=a .. [6]=g, 1 = segment lit
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: N-digit up/down BCD/hex counter on a prescaled tick,
// shown on N multiplexed common-anode digits over one shared segment bus.
//   clk, rst_n   clock, synchronous active-low reset
//   en           count enable, also gates the prescaler
//   up           1 = count up, 0 = count down
//   load         load pulse, wins over a coincident tick
//   load_value   4*N bits, digit 0 in [3:0]
//   value        current counter value
//   tick         one-cycle pulse on prescaler expiry (suppressed by load)
//   wrap         one-cycle pulse when the whole counter rolls over
//   seg          registered segments, [0]=a .. [6]=g
//   dig_sel      registered digit enables, [0] = least significant digit
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 4194304,
  parameter int SCAN_DIV       = 4096,
  parameter int GHOST_CYC      = 2,
  parameter int DECIMAL        = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GHOST_END = SW'(GHOST_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]    DMAX      = (DECIMAL != 0) ? DIG_MAX_DEC : DIG_MAX_HEX;

  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]                 presc_q, presc_d;
  logic [SW-1:0]                 scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]                 scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0][3:0]    val_q, val_d;
  logic [6:0]                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]         dig_q, dig_d;

  logic                          tick_raw;
  logic                          carry;
  logic [NUM_DIGITS-1:0][3:0]    val_step;
  logic [3:0]                    ld_dig;
  logic [3:0]                    cur_dig;
  logic [6:0]                    cur_glyph;
  logic [6:0]                    seg_act;
  logic [NUM_DIGITS-1:0]         dig_act;
  logic [NUM_DIGITS-1:0]         lz_blank;
  logic                          zero_above;
  logic                          ghost;

  // ---------------- prescaler + digit ripple counter ----------------
  always_comb begin
    tick_raw = en && (presc_q == PRESC_MAX);

    presc_d = presc_q;
    if (load)    presc_d = '0;
    else if (en) presc_d = tick_raw ? '0 : presc_q + 1'b1;

    // carry doubles as borrow; it survives the loop only if every digit rolled
    carry    = 1'b1;
    val_step = val_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (up) begin
          if (val_q[k] == DMAX) val_step[k] = 4'd0;
          else begin
            val_step[k] = val_q[k] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (val_q[k] == 4'd0) val_step[k] = DMAX;
          else begin
            val_step[k] = val_q[k] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end

    ld_dig = '0;
    val_d  = val_q;
    if (load) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        ld_dig = load_value[4*k +: 4];
        val_d[k] = (DECIMAL != 0 && ld_dig > DIG_MAX_DEC) ? DIG_MAX_DEC : ld_dig;
      end
    end else if (tick_raw) begin
      val_d = val_step;
    end
  end

  // load steals a coincident tick, so neither tick nor wrap is reported
  assign tick  = rst_n && tick_raw && !load;
  assign wrap  = tick && carry;
  assign value = val_q;

  // ---------------- scan + segment output ----------------
  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_MAX)
      scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + 1'b1;

    // walk from the top digit down: a digit is a leading zero while
    // it and everything above it is zero; digit 0 always shows
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above  = zero_above && (val_q[k] == 4'd0);
      lz_blank[k] = (BLANK_LZ != 0) && (k > 0) && zero_above;
    end

    cur_dig = val_q[scan_idx_q];
    seg_act = lz_blank[scan_idx_q] ? SEG_BLANK : cur_glyph;

    ghost = (scan_cnt_q < GHOST_END);
    for (int k = 0; k < NUM_DIGITS; k++)
      dig_act[k] = !ghost && (scan_idx_q == IW'(k));

    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_act : dig_act;
  end

  hex_to_7seg u_dec (
    .nib (cur_dig),
    .seg (cur_glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      val_q      <= '0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      val_q      <= val_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;

endmodule
